// File: rtl/pipe_control_unit.sv
// Pipelined control unit for a five-stage RV32I-style core.
// Decodes the D-stage instruction combinationally and carries the resulting
// controls through E, M and W registers. E can be flushed or stalled; M and W
// always advance. Instructions reaching W are counted in RetiredW.
module pipe_control_unit #(
  parameter int unsigned CTRL_W  = 4,
  parameter bit          EN_JALR = 1'b1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // Decode-stage instruction fields
  input  logic [6:0]        OpD,
  input  logic [2:0]        Funct3D,
  input  logic              Funct7b5D,
  input  logic              ValidD,
  // Execute-stage pipeline control
  input  logic              FlushE,
  input  logic              StallE,
  // ALU comparison flags
  input  logic              ZeroE,
  input  logic              LtE,
  input  logic              LtuE,
  // Decode-stage outputs
  output logic [2:0]        ImmSrcD,
  output logic              IllegalD,
  // Execute-stage outputs
  output logic [CTRL_W-1:0] ALUControlE,
  output logic              ALUSrcAE,
  output logic              ALUSrcBE,
  output logic              PCSrcE,
  output logic              JalrE,
  output logic              ResultSrcE0,
  // Memory-stage outputs
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  // Writeback-stage outputs
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [CNT_W-1:0]  RetiredW
);

  // Opcodes
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  // ALU operation codes
  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluAnd   = 4'd2;
  localparam logic [3:0] AluOr    = 4'd3;
  localparam logic [3:0] AluXor   = 4'd4;
  localparam logic [3:0] AluSlt   = 4'd5;
  localparam logic [3:0] AluSltu  = 4'd6;
  localparam logic [3:0] AluSll   = 4'd7;
  localparam logic [3:0] AluSrl   = 4'd8;
  localparam logic [3:0] AluSra   = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;

  // Immediate formats
  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  // Result select encodings
  localparam logic [1:0] ResAlu = 2'b00;
  localparam logic [1:0] ResMem = 2'b01;
  localparam logic [1:0] ResPc4 = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memwrite;
    logic [1:0] resultsrc;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [2:0] funct3;
    logic [3:0] alu;
    logic       srca;
    logic       srcb;
  } ex_ctl_t;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memwrite;
    logic [1:0] resultsrc;
  } late_ctl_t;

  logic [3:0] funct_alu;
  logic [2:0] imm_raw;
  logic       dec_illegal;
  logic       dec_ok;
  ex_ctl_t    dec;
  ex_ctl_t    e_d, e_q;
  late_ctl_t  m_d, m_q;
  late_ctl_t  w_q;
  logic       br_cond;
  logic [CNT_W-1:0] retired_q;

  // ALU operation selected by funct3 for register and immediate ALU ops
  always_comb begin
    case (Funct3D)
      3'b000:  funct_alu = (OpD[5] & Funct7b5D) ? AluSub : AluAdd;
      3'b001:  funct_alu = AluSll;
      3'b010:  funct_alu = AluSlt;
      3'b011:  funct_alu = AluSltu;
      3'b100:  funct_alu = AluXor;
      3'b101:  funct_alu = Funct7b5D ? AluSra : AluSrl;
      3'b110:  funct_alu = AluOr;
      3'b111:  funct_alu = AluAnd;
      default: funct_alu = AluAdd;
    endcase
  end

  // Main opcode decode; every field not used by an instruction stays 0
  always_comb begin
    dec         = '0;
    imm_raw     = ImmI;
    dec_illegal = 1'b0;
    case (OpD)
      OpLoad: begin
        dec.regwrite  = 1'b1;
        dec.resultsrc = ResMem;
        dec.srcb      = 1'b1;
        imm_raw       = ImmI;
      end
      OpStore: begin
        dec.memwrite = 1'b1;
        dec.srcb     = 1'b1;
        imm_raw      = ImmS;
      end
      OpReg: begin
        dec.regwrite = 1'b1;
        dec.alu      = funct_alu;
      end
      OpImm: begin
        dec.regwrite = 1'b1;
        dec.srcb     = 1'b1;
        dec.alu      = funct_alu;
        imm_raw      = ImmI;
        // slli encodes funct7 = 0; bit 5 set is not a valid shift
        if (Funct3D == 3'b001 && Funct7b5D) dec_illegal = 1'b1;
      end
      OpBranch: begin
        dec.branch = 1'b1;
        dec.alu    = AluSub;
        dec.funct3 = Funct3D;
        imm_raw    = ImmB;
        if (Funct3D == 3'b010 || Funct3D == 3'b011) dec_illegal = 1'b1;
      end
      OpJal: begin
        dec.regwrite  = 1'b1;
        dec.jump      = 1'b1;
        dec.resultsrc = ResPc4;
        imm_raw       = ImmJ;
      end
      OpJalr: begin
        if (EN_JALR) begin
          dec.regwrite  = 1'b1;
          dec.jump      = 1'b1;
          dec.jalr      = 1'b1;
          dec.resultsrc = ResPc4;
          dec.srcb      = 1'b1;
          imm_raw       = ImmI;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OpLui: begin
        dec.regwrite = 1'b1;
        dec.srcb     = 1'b1;
        dec.alu      = AluPassB;
        imm_raw      = ImmU;
      end
      OpAuipc: begin
        dec.regwrite = 1'b1;
        dec.srca     = 1'b1;
        dec.srcb     = 1'b1;
        imm_raw      = ImmU;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // D-stage outputs and the controls offered to E (bubble unless a legal valid op)
  always_comb begin
    dec_ok   = ValidD & ~dec_illegal;
    IllegalD = ValidD & dec_illegal;
    ImmSrcD  = dec_illegal ? 3'b000 : imm_raw;
    e_d      = '0;
    if (dec_ok) begin
      e_d       = dec;
      e_d.valid = 1'b1;
    end
  end

  // E register: flush takes priority over stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
    end else if (FlushE) begin
      e_q <= '0;
    end else if (!StallE) begin
      e_q <= e_d;
    end
  end

  // A stalled E instruction stays put, so M sees a bubble behind it
  always_comb begin
    m_d = '0;
    if (FlushE || !StallE) begin
      m_d.valid     = e_q.valid;
      m_d.regwrite  = e_q.regwrite;
      m_d.memwrite  = e_q.memwrite;
      m_d.resultsrc = e_q.resultsrc;
    end
  end

  // M and W registers advance every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      w_q <= '0;
    end else begin
      m_q <= m_d;
      w_q <= m_q;
    end
  end

  // Retired-instruction counter, wraps naturally at its width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (w_q.valid) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Branch condition from the funct3 held in E
  always_comb begin
    case (e_q.funct3)
      3'b000:  br_cond = ZeroE;
      3'b001:  br_cond = ~ZeroE;
      3'b100:  br_cond = LtE;
      3'b101:  br_cond = ~LtE;
      3'b110:  br_cond = LtuE;
      3'b111:  br_cond = ~LtuE;
      default: br_cond = 1'b0;
    endcase
  end

  // E-stage outputs; ALU code widened with zero upper bits
  always_comb begin
    ALUControlE      = '0;
    ALUControlE[3:0] = e_q.alu;
    ALUSrcAE         = e_q.srca;
    ALUSrcBE         = e_q.srcb;
    PCSrcE           = e_q.valid & (e_q.jump | (e_q.branch & br_cond));
    JalrE            = e_q.valid & e_q.jalr;
    ResultSrcE0      = e_q.resultsrc[0];
  end

  // M/W-stage outputs
  always_comb begin
    RegWriteM  = m_q.regwrite;
    MemWriteM  = m_q.memwrite;
    ResultSrcM = m_q.resultsrc;
    RegWriteW  = w_q.regwrite;
    ResultSrcW = w_q.resultsrc;
    RetiredW   = retired_q;
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Randomized bench for pipe_control_unit against a stage-by-stage reference
// model. Two instances run in lockstep: defaults, and EN_JALR=0 with CNT_W=4.
module tb_pipe_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7, vd, fl, st, z, lt, ltu;

  logic [2:0]  imm_a, imm_b;
  logic        ill_a, ill_b;
  logic [3:0]  alu_a, alu_b;
  logic        sa_a, sb_a, pc_a, jr_a, e0_a, rwm_a, mwm_a, rww_a;
  logic        sa_b, sb_b, pc_b, jr_b, e0_b, rwm_b, mwm_b, rww_b;
  logic [1:0]  rsm_a, rsw_a, rsm_b, rsw_b;
  logic [31:0] ret_a;
  logic [3:0]  ret_b;

  pipe_control_unit dut_a (
    .clk(clk), .rst_n(rst_n), .OpD(op), .Funct3D(f3), .Funct7b5D(f7), .ValidD(vd),
    .FlushE(fl), .StallE(st), .ZeroE(z), .LtE(lt), .LtuE(ltu),
    .ImmSrcD(imm_a), .IllegalD(ill_a), .ALUControlE(alu_a), .ALUSrcAE(sa_a),
    .ALUSrcBE(sb_a), .PCSrcE(pc_a), .JalrE(jr_a), .ResultSrcE0(e0_a),
    .RegWriteM(rwm_a), .MemWriteM(mwm_a), .ResultSrcM(rsm_a),
    .RegWriteW(rww_a), .ResultSrcW(rsw_a), .RetiredW(ret_a)
  );

  pipe_control_unit #(.CTRL_W(4), .EN_JALR(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .OpD(op), .Funct3D(f3), .Funct7b5D(f7), .ValidD(vd),
    .FlushE(fl), .StallE(st), .ZeroE(z), .LtE(lt), .LtuE(ltu),
    .ImmSrcD(imm_b), .IllegalD(ill_b), .ALUControlE(alu_b), .ALUSrcAE(sa_b),
    .ALUSrcBE(sb_b), .PCSrcE(pc_b), .JalrE(jr_b), .ResultSrcE0(e0_b),
    .RegWriteM(rwm_b), .MemWriteM(mwm_b), .ResultSrcM(rsm_b),
    .RegWriteW(rww_b), .ResultSrcW(rsw_b), .RetiredW(ret_b)
  );

  typedef struct packed {
    logic       v, wr, mw;
    logic [1:0] rs;
    logic       br, jmp, jalr;
    logic [2:0] f3;
    logic [3:0] alu;
    logic       sa, sb;
    logic [2:0] imm;
    logic       legal;
  } ref_t;

  ref_t        me [2];
  ref_t        mm [2];
  ref_t        mw [2];
  int unsigned mcnt [2];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Instruction meaning straight from the ISA table
  function automatic ref_t ref_decode(input logic [6:0] o, input logic [2:0] fn3,
                                      input logic b5, input bit enj);
    ref_t r;
    logic [3:0] tab [8];
    tab = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    r = '0;
    r.legal = 1'b1;
    case (o)
      7'b0000011: begin r.wr = 1; r.rs = 2'b01; r.sb = 1; r.imm = 3'd0; end
      7'b0100011: begin r.mw = 1; r.sb = 1; r.imm = 3'd1; end
      7'b0110011, 7'b0010011: begin
        r.wr  = 1;
        r.sb  = (o == 7'b0010011);
        r.alu = tab[fn3];
        if (fn3 == 3'd5 && b5) r.alu = 4'd9;
        if (fn3 == 3'd0 && b5 && o == 7'b0110011) r.alu = 4'd1;
        if (o == 7'b0010011 && fn3 == 3'd1 && b5) r.legal = 0;
      end
      7'b1100011: begin
        r.br = 1; r.alu = 4'd1; r.imm = 3'd2; r.f3 = fn3;
        if (fn3 == 3'd2 || fn3 == 3'd3) r.legal = 0;
      end
      7'b1101111: begin r.wr = 1; r.jmp = 1; r.rs = 2'b10; r.imm = 3'd3; end
      7'b1100111: begin
        if (enj) begin r.wr = 1; r.jmp = 1; r.jalr = 1; r.rs = 2'b10; r.sb = 1; end
        else r.legal = 0;
      end
      7'b0110111: begin r.wr = 1; r.sb = 1; r.alu = 4'd10; r.imm = 3'd4; end
      7'b0010111: begin r.wr = 1; r.sa = 1; r.sb = 1; r.imm = 3'd4; end
      default: r.legal = 0;
    endcase
    if (!r.legal) r = '0;
    return r;
  endfunction

  function automatic logic taken(input logic [2:0] c, input logic zz, ll, uu);
    case (c)
      3'd0: return zz;
      3'd1: return !zz;
      3'd4: return ll;
      3'd5: return !ll;
      3'd6: return uu;
      3'd7: return !uu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      me[k] = '0; mm[k] = '0; mw[k] = '0; mcnt[k] = 0;
    end
  endtask

  // One clock of the reference pipeline, using the inputs present at the edge
  task automatic model_advance();
    ref_t d;
    if (!rst_n) begin
      model_clear();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (mw[k].v) mcnt[k]++;
      mw[k] = mm[k];
      mm[k] = (st && !fl) ? '0 : me[k];
      if (fl) me[k] = '0;
      else if (!st) begin
        d = ref_decode(op, f3, f7, k == 0);
        if (vd && d.legal) begin
          me[k] = d;
          me[k].v = 1'b1;
        end else me[k] = '0;
      end
    end
  endtask

  task automatic compare_one(input string p, input int k, input logic [2:0] imm,
                             input logic ill, input logic [3:0] alu, input logic sa, sb, pc,
                             jr, e0, rwm, mwm, input logic [1:0] rsm, input logic rww,
                             input logic [1:0] rsw, input logic [31:0] ret);
    ref_t d;
    logic [31:0] exp_ret;
    d = ref_decode(op, f3, f7, k == 0);
    exp_ret = (k == 0) ? mcnt[0] : (mcnt[1] & 32'hF);
    check({p, ".imm"}, 32'(imm), 32'(d.imm));
    check({p, ".illegal"}, 32'(ill), 32'(vd && !d.legal && (op != 7'b0 || 1'b1)));
    check({p, ".alu"}, 32'(alu), 32'(me[k].alu));
    check({p, ".srca"}, 32'(sa), 32'(me[k].sa));
    check({p, ".srcb"}, 32'(sb), 32'(me[k].sb));
    check({p, ".pcsrc"}, 32'(pc),
          32'(me[k].v && (me[k].jmp || (me[k].br && taken(me[k].f3, z, lt, ltu)))));
    check({p, ".jalr"}, 32'(jr), 32'(me[k].v && me[k].jalr));
    check({p, ".load_e"}, 32'(e0), 32'(me[k].rs == 2'b01));
    check({p, ".regwrite_m"}, 32'(rwm), 32'(mm[k].wr));
    check({p, ".memwrite_m"}, 32'(mwm), 32'(mm[k].mw));
    check({p, ".resultsrc_m"}, 32'(rsm), 32'(mm[k].rs));
    check({p, ".regwrite_w"}, 32'(rww), 32'(mw[k].wr));
    check({p, ".resultsrc_w"}, 32'(rsw), 32'(mw[k].rs));
    check({p, ".retired"}, ret, exp_ret);
  endtask

  task automatic compare_all();
    compare_one("a", 0, imm_a, ill_a, alu_a, sa_a, sb_a, pc_a, jr_a, e0_a, rwm_a, mwm_a,
                rsm_a, rww_a, rsw_a, ret_a);
    compare_one("b", 1, imm_b, ill_b, alu_b, sa_b, sb_b, pc_b, jr_b, e0_b, rwm_b, mwm_b,
                rsm_b, rww_b, rsw_b, 32'(ret_b));
  endtask

  task automatic step(input logic [6:0] o, input logic [2:0] fn3, input logic b5,
                      input logic v, input logic fl_i, input logic st_i,
                      input logic z_i, input logic lt_i, input logic ltu_i);
    @(posedge clk);
    model_advance();
    #1;
    op = o; f3 = fn3; f7 = b5; vd = v; fl = fl_i; st = st_i; z = z_i; lt = lt_i; ltu = ltu_i;
    @(negedge clk);
    compare_all();
  endtask

  task automatic issue(input logic [6:0] o, input logic [2:0] fn3, input logic b5);
    step(o, fn3, b5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset with a load sitting in D; state must clear without an edge
  task automatic pulse_reset();
    #2;
    op = 7'b0000011; f3 = 3'b010; f7 = 1'b0; vd = 1'b1; fl = 1'b0; st = 1'b0;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("rst.alu", 32'(alu_a), 32'd0);
    check("rst.load_e", 32'(e0_a), 32'd0);
    check("rst.regwrite_m", 32'(rwm_a), 32'd0);
    check("rst.regwrite_w", 32'(rww_a), 32'd0);
    check("rst.retired_a", ret_a, 32'd0);
    check("rst.retired_b", 32'(ret_b), 32'd0);
    check("rst.imm_follows", 32'(imm_a), 32'd0);
    check("rst.illegal_follows", 32'(ill_a), 32'd0);
    @(posedge clk);
    model_advance();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [6:0]  ops [9];
  int unsigned saved;
  int          need;

  initial begin
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    rst_n = 1'b0;
    op = 7'b0000011; f3 = 3'b010; f7 = 1'b0; vd = 1'b1;
    fl = 1'b0; st = 1'b0; z = 1'b0; lt = 1'b0; ltu = 1'b0;
    model_clear();
    #1;
    check("por.load_e", 32'(e0_a), 32'd0);
    check("por.regwrite_w", 32'(rww_a), 32'd0);
    check("por.retired", ret_a, 32'd0);
    compare_all();
    @(negedge clk);
    @(negedge clk);
    vd = 1'b0; op = 7'd0;
    rst_n = 1'b1;

    // lw, add, sw back to back
    issue(7'b0000011, 3'b010, 1'b0);
    issue(7'b0110011, 3'b000, 1'b0);
    check("lw.load_e", 32'(e0_a), 32'd1);
    issue(7'b0100011, 3'b010, 1'b0);
    idle(1);
    check("lw.regwrite_w", 32'(rww_a), 32'd1);
    check("lw.resultsrc_w", 32'(rsw_a), 32'd1);
    idle(3);
    check("lw_add_sw.retired", ret_a, 32'd3);

    // bne taken then not taken while held in E, then bltu
    issue(7'b1100011, 3'b001, 1'b0);
    step(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bne.z0", 32'(pc_a), 32'd1);
    step(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("bne.z1", 32'(pc_a), 32'd0);
    issue(7'b1100011, 3'b110, 1'b0);
    step(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bltu.ltu1", 32'(pc_a), 32'd1);

    // ALU selections
    issue(7'b0110011, 3'b101, 1'b1);
    idle(1);
    check("sra.alu", 32'(alu_a), 32'd9);
    issue(7'b0110011, 3'b000, 1'b1);
    idle(1);
    check("sub.alu", 32'(alu_a), 32'd1);
    issue(7'b0110111, 3'b011, 1'b1);
    idle(1);
    check("lui.alu", 32'(alu_a), 32'd10);
    check("lui.srcb", 32'(sb_a), 32'd1);

    // jal with flush and stall together never enters E
    idle(5);
    saved = mcnt[0];
    step(7'b1101111, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("jal_flush.pcsrc", 32'(pc_a), 32'd0);
    idle(4);
    check("jal_flush.retired", ret_a, saved);

    // jalr illegal when disabled
    issue(7'b1100111, 3'b000, 1'b0);
    check("jalr_off.illegal", 32'(ill_b), 32'd1);
    check("jalr_on.illegal", 32'(ill_a), 32'd0);
    idle(1);
    check("jalr_on.pcsrc", 32'(pc_a), 32'd1);
    check("jalr_off.pcsrc", 32'(pc_b), 32'd0);
    idle(1);
    check("jalr_off.regwrite_m", 32'(rwm_b), 32'd0);
    idle(1);
    check("jalr_off.regwrite_w", 32'(rww_b), 32'd0);
    check("jalr_on.regwrite_w", 32'(rww_a), 32'd1);

    // 4-bit counter wraps from 15 to 0
    idle(4);
    need = int'((15 - (mcnt[1] % 16)) % 16);
    for (int i = 0; i < need; i++) issue(7'b0010011, 3'b000, 1'b0);
    idle(4);
    check("wrap.at15", 32'(ret_b), 32'd15);
    issue(7'b0010011, 3'b000, 1'b0);
    idle(4);
    check("wrap.to0", 32'(ret_b), 32'd0);

    // Randomized traffic with occasional mid-pipeline resets
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      step(($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)],
           3'($urandom), 1'($urandom), ($urandom_range(0, 99) < 85),
           ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 15),
           1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
